uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 13 +
 rtl/fifo_regfile.sv | 25 ++
 rtl/uart_rx_fifo.sv | 132 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive FIFO.
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic {
    ERR_IDLE,
    ERR_CLEAR
  } err_state_t;

  localparam int UART_RX_FIFO_DEPTH_DEF = 8;

endpackage : uart_pkg

// File: rtl/fifo_regfile.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
// Entries are not reset; validity is tracked by the owner's count.
module fifo_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry on an accepted push.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule : fifo_regfile

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO between a UART receiver and a host.
// Optional feature macro: UART_RX_FIFO_ERR_TAG_EN stores a framing-error tag
// with each byte and pulses clear_err back to the receiver after a tagged push.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = UART_RX_FIFO_DEPTH_DEF,
  parameter int THRESHOLD = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_framing_err,
  output logic                     clear_err,
  output logic [7:0]               out_data,
  output logic                     out_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     thresh_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam int W = 9;
`else
  localparam int W = 8;
`endif
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESHOLD);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic [W-1:0]  wr_data, rd_data, last_q;
  logic          push, pop, empty;
  uart_byte_t    head_byte;

  assign empty      = (count_q == '0);
  assign in_ready   = (count_q != DEPTH_C);
  assign out_valid  = !empty;
  // flush wins over both directions of traffic
  assign push       = in_valid && in_ready && !flush;
  assign pop        = out_valid && out_ready && !flush;
  assign count      = count_q;
  assign thresh_irq = (count_q >= THRESH_C);

`ifdef UART_RX_FIFO_ERR_TAG_EN
  assign wr_data = {in_framing_err, in_data};
`else
  assign wr_data = in_data;
`endif

  fifo_regfile #(
    .WIDTH (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Pointers wrap naturally since DEPTH is a power of two; count is explicit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Remember the most recently popped entry so the outputs hold it when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      last_q <= '0;
    else if (pop) last_q <= rd_data;
  end

  assign head_byte = empty ? last_q[7:0] : rd_data[7:0];
  assign out_data  = head_byte;

`ifdef UART_RX_FIFO_ERR_TAG_EN
  err_state_t err_state, err_next;

  assign out_err = empty ? last_q[8] : rd_data[8];

  // Error-clear FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_state <= ERR_IDLE;
    else     err_state <= err_next;
  end

  // A tagged push requests one clear pulse toward the receiver.
  always_comb begin
    err_next  = err_state;
    clear_err = 1'b0;
    case (err_state)
      ERR_IDLE:  if (push && in_framing_err) err_next = ERR_CLEAR;
      ERR_CLEAR: begin
        clear_err = 1'b1;
        err_next  = ERR_IDLE;
      end
      default:   err_next = ERR_IDLE;
    endcase
  end
`else
  logic unused_framing_err;

  assign unused_framing_err = in_framing_err;
  assign out_err            = 1'b0;
  assign clear_err          = 1'b0;
`endif

endmodule : uart_rx_fifo
